tm1638_frame_sched: RTL and testbench

Frame scheduler and framebuffer for the TM1638 display link. It holds a 16-byte display image and the display settings, and decides when a refresh frame is sent. It sequences each frame as TM1638 command/data bytes to the downstream serial shifter (PHY) over a valid/ready byte handshake. Each byte is tagged with where the strobe must be released. It sits between the user logic that writes segment patterns and the bit-level PHY that drives the clock, strobe and data pins.

---
 rtl/tm1638_frame_sched.sv | 123 ++++++++++++
 tb/tb_tm1638_frame_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_frame_sched.sv
// TM1638 frame scheduler: 16-byte framebuffer plus display settings, emitted as
// 19-byte refresh frames (mode, address, 16 data, display control) to the PHY.
module tm1638_frame_sched #(
  parameter int unsigned REFRESH_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] bright,
  input  logic       disp_on,
  input  logic       force_update,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int TW = $clog2(REFRESH_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MODE, ADDR, DATA, DISP, DONE} state_t;

  state_t          state;
  logic [15:0][7:0] fb;
  logic [3:0]      idx;
  logic [3:0]      idx_nx;
  logic [TW-1:0]   timer;
  logic            dirty;
  logic            refresh_pend;
  logic [2:0]      cfg_bright;
  logic            cfg_on;
  logic            hs;
  logic            trigger;
  logic            wrap;

  assign hs      = tx_valid & tx_ready;
  assign trigger = dirty | refresh_pend | force_update;
  assign wrap    = (timer == TMAX);
  assign idx_nx  = idx + 4'd1;

  always_ff @(posedge clk) begin
    if (rst)        fb <= '0;
    else if (wr_en) fb[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      tx_last      <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      dirty        <= 1'b1;
      refresh_pend <= 1'b0;
      timer        <= '0;
      cfg_bright   <= '0;
      cfg_on       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      timer      <= wrap ? '0 : timer + 1'b1;
      if (wrap || (force_update && state != IDLE)) refresh_pend <= 1'b1;
      if (wr_en) dirty <= 1'b1;

      case (state)
        IDLE: if (trigger) begin
          // a write landing on the start cycle keeps dirty so it is resent
          if (!wr_en) dirty <= 1'b0;
          refresh_pend <= 1'b0;
          // the start cycle counts as tick 0, so periodic starts are exactly
          // REFRESH_CYCLES apart
          timer      <= TW'(1);
          cfg_bright <= bright;
          cfg_on     <= disp_on;
          state      <= MODE;
          busy       <= 1'b1;
          tx_valid   <= 1'b1;
          tx_data    <= 8'h40;
          tx_last    <= 1'b1;
        end
        MODE: if (hs) begin
          state   <= ADDR;
          tx_data <= 8'hC0;
          tx_last <= 1'b0;
        end
        ADDR: if (hs) begin
          state   <= DATA;
          idx     <= '0;
          tx_data <= fb[0];
          tx_last <= 1'b0;
        end
        DATA: if (hs) begin
          if (idx == 4'd15) begin
            state   <= DISP;
            tx_data <= {4'b1000, cfg_on, cfg_bright};
            tx_last <= 1'b1;
          end else begin
            idx     <= idx_nx;
            tx_data <= fb[idx_nx];
            tx_last <= (idx_nx == 4'd15);
          end
        end
        DISP: if (hs) begin
          state      <= DONE;
          tx_valid   <= 1'b0;
          tx_last    <= 1'b0;
          frame_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_frame_sched.sv
// Scoreboard bench for tm1638_frame_sched: a frame image is queued from the
// bench's own framebuffer model at each frame start and popped per handshake.
module tb_tm1638_frame_sched;
  localparam int R = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] bright = '0;
  logic       disp_on = 1'b0;
  logic       force_update = 1'b0;
  logic       tx_ready = 1'b1;
  logic       tx_valid, tx_last, busy, frame_done;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  tm1638_frame_sched #(.REFRESH_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bright(bright), .disp_on(disp_on), .force_update(force_update),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // behavioural model: what the user has written and the settings it drives
  logic [7:0] fb_m [16];
  logic [2:0] br_m;
  logic       on_m;

  typedef struct packed { logic [7:0] d; logic l; } ent_t;
  ent_t exp_q[$];
  int   start_q[$];

  function automatic void push_frame();
    exp_q.push_back(ent_t'{d: 8'h40, l: 1'b1});
    exp_q.push_back(ent_t'{d: 8'hC0, l: 1'b0});
    for (int i = 0; i < 16; i++) exp_q.push_back(ent_t'{d: fb_m[i], l: (i == 15)});
    exp_q.push_back(ent_t'{d: 8'h80 + (int'(on_m) * 8) + int'(br_m), l: 1'b1});
  endfunction

  // monitor
  logic       prev_busy = 1'b0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;
  int         frame_bytes = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_busy = 1'b0;
      hold_v = 1'b0;
      frame_bytes = 0;
    end else begin
      if (busy && !prev_busy) begin
        start_q.push_back(cyc);
        frame_bytes = 0;
        push_frame();
      end
      if (tx_valid && hold_v) chk("stall_hold", {tx_data, tx_last}, {hold_d, hold_l});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_byte");
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk($sformatf("byte%0d", frame_bytes), {tx_data, tx_last}, {e.d, e.l});
        end
        frame_bytes++;
        hold_v = 1'b0;
      end else if (tx_valid) begin
        hold_v = 1'b1;
        hold_d = tx_data;
        hold_l = tx_last;
      end else begin
        hold_v = 1'b0;
      end
      if (frame_done) begin
        chk("frame_len", frame_bytes, 19);
        chk("queue_empty_at_done", exp_q.size(), 0);
      end
      prev_busy = busy;
    end
  end

  // PHY ready driver: 0 = always ready, 1 = random, 2 = five-cycle stall on 0xC0
  int mode = 0;
  int stall_n = 0;
  always @(posedge clk) begin
    #2;
    case (mode)
      1: tx_ready = ($urandom_range(0, 3) != 0);
      2: if (tx_valid && tx_data == 8'hC0 && stall_n < 5) begin
           tx_ready = 1'b0;
           stall_n++;
         end else tx_ready = 1'b1;
      default: tx_ready = 1'b1;
    endcase
  end

  // handshakes completed in the current frame = index of the byte on the bus
  int pos_cnt = 0;
  always @(posedge clk) begin
    if (rst || frame_done) pos_cnt <= 0;
    else if (tx_valid && tx_ready) pos_cnt <= pos_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; fb_m[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_force();
    force_update = 1'b1;
    tick();
    force_update = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin tick(); n++; end
    if (!frame_done) timeout(name);
    tick();
  endtask

  task automatic wait_starts(input string name, input int k, input int budget);
    int n = 0;
    while (start_q.size() < k && n < budget) begin tick(); n++; end
    if (start_q.size() < k) timeout(name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int n;
    for (int i = 0; i < 16; i++) fb_m[i] = 8'h00;
    br_m = 3'd0;
    on_m = 1'b0;

    // reset state, then an immediate blank display-off frame
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_last", tx_last, 0);
    rst = 1'b0;
    tick();
    chk("first_frame_latency_valid", tx_valid, 1);
    chk("first_frame_latency_busy", busy, 1);
    wait_done("first_frame", 60);

    // periodic refresh with no writes
    wait_starts("periodic", 3, 300);
    if (start_q.size() >= 3) begin
      chk("refresh_period_1", start_q[1] - start_q[0], R);
      chk("refresh_period_2", start_q[2] - start_q[1], R);
    end
    wait_done("periodic_done", 60);

    // user writes with new settings while idle
    repeat (3) tick();
    bright = 3'd3; disp_on = 1'b1; br_m = 3'd3; on_m = 1'b1;
    n0 = start_q.size();
    wr(4'd0, 8'h3F);
    wr(4'd2, 8'h06);
    wait_starts("write_frames", n0 + 3, 300);
    if (start_q.size() >= n0 + 3) begin
      chk("write_resend_gap", start_q[n0 + 1] - start_q[n0], 21);
      chk("idle_until_wrap", start_q[n0 + 2] - start_q[n0 + 1], R);
    end
    wait_done("write_periodic_done", 60);

    // five-cycle stall on the address byte
    tick();
    stall_n = 0;
    mode = 2;
    pulse_force();
    wait_done("stall_frame", 80);
    chk("stall_cycles", stall_n, 5);
    mode = 1;

    // write + force mid-frame at data byte 5, random back-pressure
    tick();
    pulse_force();
    n = 0;
    while (!(busy && tx_valid && pos_cnt == 7) && n < 300) begin tick(); n++; end
    if (n >= 300) timeout("reach_data5");
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hFF; fb_m[3] = 8'hFF;
    force_update = 1'b1;
    tick();
    wr_en = 1'b0;
    force_update = 1'b0;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    if (busy) timeout("busy_fall");
    tick();
    chk("restart_after_busy_fall", busy, 1);
    chk("restart_tx_valid", tx_valid, 1);
    wait_done("second_frame", 300);
    mode = 0;

    // reset in the middle of a frame at data byte 8
    tick();
    pulse_force();
    n = 0;
    while (!(busy && pos_cnt == 10) && n < 80) begin tick(); n++; end
    if (n >= 80) timeout("reach_data8");
    rst = 1'b1;
    bright = 3'd0; disp_on = 1'b0; br_m = 3'd0; on_m = 1'b0;
    for (int i = 0; i < 16; i++) fb_m[i] = 8'h00;
    tick();
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_last", tx_last, 0);
    n0 = start_q.size();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_frame", tx_valid, 1);
    wait_done("post_rst_done", 60);
    chk("post_rst_one_frame", start_q.size(), n0 + 1);

    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
